alu_issue: RTL and testbench

Issue controller that sits between the decode stage and the ALU. It accepts one instruction plus its register operands over a valid/ready handshake and decodes the MIPS opcode/funct into the ALU op code. It then drives the ALU operand and op inputs, waits out the ALU's registered result latency, and returns the result with zero/trap/illegal flags over a second valid/ready handshake toward writeback.

---
 rtl/alu_issue.sv | 163 ++++++++++++++++
 tb/tb_alu_issue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue controller between decode and a one-cycle registered ALU: decodes MIPS ops, holds operands, returns result/flags.
// Optional overflow trapping on ADD/ADDI/SUB is enabled by defining ALU_ISSUE_TRAP_EN.
module alu_issue #(
   parameter int WIDTH    = 32,
   parameter int OP_WIDTH = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [WIDTH-1:0]    in_rs_val,
   input  logic [WIDTH-1:0]    in_rt_val,
   output logic [OP_WIDTH-1:0] alu_op,
   output logic [WIDTH-1:0]    alu_a,
   output logic [WIDTH-1:0]    alu_b,
   input  logic [WIDTH-1:0]    alu_result,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_result,
   output logic                out_zero,
   output logic                out_trap,
   output logic                out_illegal
);

   localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(4);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t               state_q;
   logic [OP_WIDTH-1:0]  alu_op_q;
   logic [WIDTH-1:0]     alu_a_q, alu_b_q;
   logic [WIDTH-1:0]     out_result_q;
   logic                 out_zero_q, out_illegal_q;

   logic [5:0]           opcode, funct;
   logic [15:0]          imm;
   logic                 legal_d, trap_op_d;
   logic [OP_WIDTH-1:0]  op_d;
   logic [WIDTH-1:0]     b_d;

   assign opcode = in_instr[31:26];
   assign funct  = in_instr[5:0];
   assign imm    = in_instr[15:0];

   always_comb begin
      legal_d   = 1'b1;
      trap_op_d = 1'b0;
      op_d      = OP_ADD;
      b_d       = in_rt_val;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20: begin op_d = OP_ADD; trap_op_d = 1'b1; end
               6'h21: op_d = OP_ADD;
               6'h22: begin op_d = OP_SUB; trap_op_d = 1'b1; end
               6'h23: op_d = OP_SUB;
               6'h24: op_d = OP_AND;
               6'h25: op_d = OP_OR;
               6'h2A: op_d = OP_SLT;
               default: legal_d = 1'b0;
            endcase
         end
         6'h08: begin op_d = OP_ADD; b_d = WIDTH'($signed(imm)); trap_op_d = 1'b1; end
         6'h09: begin op_d = OP_ADD; b_d = WIDTH'($signed(imm)); end
         6'h0A: begin op_d = OP_SLT; b_d = WIDTH'($signed(imm)); end
         6'h0C: begin op_d = OP_AND; b_d = WIDTH'(imm); end
         6'h0D: begin op_d = OP_OR;  b_d = WIDTH'(imm); end
         6'h04: op_d = OP_SUB;
         default: legal_d = 1'b0;
      endcase
   end

`ifdef ALU_ISSUE_TRAP_EN
   logic trap_op_q, out_trap_q, ovf;
   // Sign-bit overflow check on the held operands against the ALU's registered result.
   always_comb begin
      ovf = 1'b0;
      if (alu_op_q == OP_ADD)
         ovf = (alu_a_q[WIDTH-1] == alu_b_q[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a_q[WIDTH-1]);
      else if (alu_op_q == OP_SUB)
         ovf = (alu_a_q[WIDTH-1] != alu_b_q[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a_q[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_op_q  <= 1'b0;
         out_trap_q <= 1'b0;
      end else begin
         if (state_q == IDLE && in_valid) begin
            trap_op_q  <= trap_op_d;
            out_trap_q <= 1'b0;
         end else if (state_q == CAPTURE) begin
            out_trap_q <= trap_op_q && ovf;
         end
      end
   end

   assign out_trap = out_trap_q;

   logic unused_fields;
   assign unused_fields = ^in_instr[25:16];
`else
   assign out_trap = 1'b0;

   logic unused_fields;
   assign unused_fields = ^{in_instr[25:16], trap_op_d};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         alu_op_q      <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         out_result_q  <= '0;
         out_zero_q    <= 1'b0;
         out_illegal_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (legal_d) begin
                     alu_op_q <= op_d;
                     alu_a_q  <= in_rs_val;
                     alu_b_q  <= b_d;
                     state_q  <= ISSUE;
                  end else begin
                     // Illegal ops bypass the ALU; operand registers keep the previous instruction.
                     out_result_q  <= '0;
                     out_zero_q    <= 1'b0;
                     out_illegal_q <= 1'b1;
                     state_q       <= RESP;
                  end
               end
            end
            ISSUE:   state_q <= CAPTURE;
            CAPTURE: begin
               out_result_q  <= alu_result;
               out_zero_q    <= (alu_result == '0);
               out_illegal_q <= 1'b0;
               state_q       <= RESP;
            end
            RESP:    if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == RESP);
   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign out_result  = out_result_q;
   assign out_zero    = out_zero_q;
   assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural one-cycle registered ALU; expected values are hand-computed.
module tb_alu_issue;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_instr;
   logic [W-1:0]  in_rs_val, in_rt_val;
   logic [2:0]    alu_op;
   logic [W-1:0]  alu_a, alu_b;
   logic [W-1:0]  alu_result;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_result;
   logic          out_zero, out_trap, out_illegal;

   int checks = 0;
   int errors = 0;

`ifdef ALU_ISSUE_TRAP_EN
   localparam logic TRAP_ON = 1'b1;
`else
   localparam logic TRAP_ON = 1'b0;
`endif

   alu_issue #(.WIDTH(W), .OP_WIDTH(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_rs_val   (in_rs_val),
      .in_rt_val   (in_rt_val),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_zero    (out_zero),
      .out_trap    (out_trap),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   // Registered ALU stand-in.
   always @(posedge clk) begin
      case (alu_op)
         3'd0:    alu_result <= alu_a & alu_b;
         3'd1:    alu_result <= alu_a | alu_b;
         3'd2:    alu_result <= alu_a + alu_b;
         3'd3:    alu_result <= alu_a - alu_b;
         3'd4:    alu_result <= ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_result <= '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_legal(input string name, input logic [31:0] instr,
                            input logic [W-1:0] rs, input logic [W-1:0] rt,
                            input logic [2:0] exp_op, input logic [W-1:0] exp_b,
                            input logic [W-1:0] exp_res, input logic exp_zero,
                            input logic exp_trap, input int hold);
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = instr;
      in_rs_val = rs;
      in_rt_val = rt;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({name, ".alu_op"}, 32'(alu_op), 32'(exp_op));
      check({name, ".alu_a"}, alu_a, rs);
      check({name, ".alu_b"}, alu_b, exp_b);
      check({name, ".vld_n0"}, 32'(out_valid), 32'd0);
      check({name, ".rdy_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check({name, ".vld_n1"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check({name, ".vld_n2"}, 32'(out_valid), 32'd1);
      check({name, ".result"}, out_result, exp_res);
      check({name, ".zero"}, 32'(out_zero), 32'(exp_zero));
      check({name, ".trap"}, 32'(out_trap), 32'(exp_trap));
      check({name, ".illegal"}, 32'(out_illegal), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, ".hold_vld"}, 32'(out_valid), 32'd1);
         check({name, ".hold_res"}, out_result, exp_res);
         check({name, ".hold_zero"}, 32'(out_zero), 32'(exp_zero));
         check({name, ".hold_rdy"}, 32'(in_ready), 32'd0);
         check({name, ".hold_op"}, 32'(alu_op), 32'(exp_op));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({name, ".done_rdy"}, 32'(in_ready), 32'd1);
      check({name, ".done_vld"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_rs_val = '0;
      in_rt_val = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.alu_op", 32'(alu_op), 32'd0);
      check("rst.alu_a", alu_a, 32'd0);
      check("rst.alu_b", alu_b, 32'd0);
      check("rst.out_result", out_result, 32'd0);
      check("rst.flags", {29'd0, out_zero, out_trap, out_illegal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //          name     instr         rs            rt            op    b             result        z     trap     hold
      run_legal("add",   32'h00221820, 32'd5,        32'd7,        3'd2, 32'd7,        32'd12,       1'b0, 1'b0,    0);
      run_legal("andi",  32'h3022FFFF, 32'h12345678, 32'hDEADBEEF, 3'd0, 32'h0000FFFF, 32'h00005678, 1'b0, 1'b0,    0);
      run_legal("slti",  32'h2822FFFF, 32'd0,        32'd9,        3'd4, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0,    0);
      run_legal("beq",   32'h10220000, 32'h55,       32'h55,       3'd3, 32'h55,       32'd0,        1'b1, 1'b0,    3);
      run_legal("addov", 32'h00221820, 32'h7FFFFFFF, 32'd1,        3'd2, 32'd1,        32'h80000000, 1'b0, TRAP_ON, 0);
      run_legal("adduov",32'h00221821, 32'h7FFFFFFF, 32'd1,        3'd2, 32'd1,        32'h80000000, 1'b0, 1'b0,    0);
      run_legal("subov", 32'h00221822, 32'h80000000, 32'd1,        3'd3, 32'd1,        32'h7FFFFFFF, 1'b0, TRAP_ON, 0);
      run_legal("or",    32'h00221825, 32'hF0,       32'h0F,       3'd1, 32'h0F,       32'hFF,       1'b0, 1'b0,    0);
      run_legal("slt",   32'h0022182A, 32'hFFFFFFFF, 32'd1,        3'd4, 32'd1,        32'd1,        1'b0, 1'b0,    0);
      run_legal("ori",   32'h34228001, 32'd0,        32'd3,        3'd1, 32'h00008001, 32'h00008001, 1'b0, 1'b0,    0);
      run_legal("addi",  32'h2022FFFF, 32'd5,        32'd3,        3'd2, 32'hFFFFFFFF, 32'd4,        1'b0, 1'b0,    0);

      // Illegal opcode: operands from "addi" must survive.
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = 32'hFC000000;
      in_rs_val = 32'h11111111;
      in_rt_val = 32'h22222222;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("ill.out_valid", 32'(out_valid), 32'd1);
      check("ill.illegal", 32'(out_illegal), 32'd1);
      check("ill.result", out_result, 32'd0);
      check("ill.zero_trap", {30'd0, out_zero, out_trap}, 32'd0);
      check("ill.alu_op", 32'(alu_op), 32'd2);
      check("ill.alu_a", alu_a, 32'd5);
      check("ill.alu_b", alu_b, 32'hFFFFFFFF);
      @(posedge clk); #1;
      check("ill.done_rdy", 32'(in_ready), 32'd1);
      check("ill.done_vld", 32'(out_valid), 32'd0);

      // Reset while in CAPTURE drops the instruction.
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = 32'h00221820;
      in_rs_val = 32'd100;
      in_rt_val = 32'd23;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mrst.in_ready", 32'(in_ready), 32'd1);
      check("mrst.out_valid", 32'(out_valid), 32'd0);
      check("mrst.alu_op", 32'(alu_op), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("mrst.no_vld", 32'(out_valid), 32'd0);
         check("mrst.rdy", 32'(in_ready), 32'd1);
      end
      run_legal("add2", 32'h00221820, 32'd100, 32'd23, 3'd2, 32'd23, 32'd123, 1'b0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
